sram_resp_16x4: RTL and testbench
=================================

Name: sram_resp_16x4

Overview:
- Synthesizable responder side of the 16x4 SRAM access protocol. Request initiators (testbenches, BIST, CPU glue) issue read/write transactions over a valid/ready handshake.
- Holds a 16-entry x 4-bit storage array and returns registered read data with a valid strobe.
- Clears the whole array with a hardware sweep on reset and on request, so initiators never read stale contents.

Parameters:
- DW, 4, data width in bits.
- AW, 4, address width in bits; DEPTH = 2**AW entries (16).

Ports:
- clk  input  1  single clock, all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  initiator presents a transaction.
- req_ready  output  1  responder can accept; req_ready = (state==IDLE) && !clr_req (combinational).
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  AW  target address.
- req_data  input  DW  write data, ignored for reads.
- rd_valid  output  1  one-cycle strobe: rd_data is valid.
- rd_data  output  DW  registered read data.
- clr_req  input  1  pulse to start a full-array clear.
- busy  output  1  high while in CLEAR.
- par_err  output  1  parity error flag, qualified by rd_valid (tied 0 without PARITY_EN).
- err_inject  input  1  exists only with PARITY_EN; corrupts the stored parity bit of the current write.

Behaviour:
- Reset (rst=1 at an edge):
  - state<=CLEAR, clr_ptr<=0.
  - rd_valid<=0, rd_data<=0, par_err<=0; busy=1, req_ready=0.
- FSM states: CLEAR, IDLE.
- CLEAR state:
  - Each cycle writes mem[clr_ptr]<=0 (parity bit 0 under PARITY_EN), then clr_ptr increments.
  - On the edge that writes entry DEPTH-1, state<=IDLE.
  - After rst deasserts, req_ready first goes high in the DEPTH-th cycle (cycle 16 counting from 0).
- IDLE state: a handshake occurs when req_valid && req_ready at the rising edge.
  - Write: mem[req_addr]<=req_data on that edge; no response.
  - Read: rd_data<=mem[req_addr] on that edge, rd_valid=1 for exactly the following cycle. Read latency is 1 cycle.
- Throughput: one transaction per cycle, reads and writes freely interleaved.
  - A read issued in the cycle after a write to the same address returns the new data.
- rd_data holds its last value when rd_valid=0.
- rd_valid deasserts the cycle after a read unless another read was accepted.
- clr_req in IDLE:
  - Next edge: state<=CLEAR, clr_ptr<=0.
  - The same-cycle request is not accepted (req_ready=0 because clr_req=1), so clear wins any collision.
  - A read accepted on the previous edge still delivers its rd_valid.
- clr_req during CLEAR is ignored; the sweep neither restarts nor extends.
- rst asserted mid-CLEAR restarts the sweep from entry 0.
- rst asserted the cycle after a read accept forces rd_valid<=0; that response is dropped.
- Address and pointer arithmetic is modulo DEPTH, and clr_ptr wraps naturally to 0.

Optional Feature:
- Macro: SRAM_RESP_PARITY_EN.
- Defined:
  - Each entry is DW+1 bits; the stored bit is the even parity of data XOR err_inject.
  - On each read, par_err is registered alongside rd_data: par_err=1 when the stored parity mismatches the recomputed parity. It is valid only with rd_valid, otherwise 0.
  - Clear writes data 0 and parity 0.
- Not defined: entries are DW bits, err_inject port absent, par_err constant 0.

Test Plan:
- Reset/clear timing: hold rst 2 cycles, release, keep req_valid=1 -> req_ready=0 and busy=1 for 16 cycles, then req_ready=1/busy=0; read every address -> rd_data=4'b0000.
- Golden sweep: write addr i with data 15-i for i=0..15, then read i=0..15 back-to-back -> each rd_valid one cycle after accept, rd_data=15-i, rd_valid continuously high for 16 cycles.
- Read-after-write: write addr 5 = 4'b1010, read addr 5 next cycle -> rd_data=4'b1010 one cycle later.
- Clear collision: assert clr_req with req_valid=1, wr, addr 3, data 4'b0110 -> req_ready=0, no write; after 16 cycles read addr 3 -> 4'b0000.
- Reset mid-clear: pulse clr_req, assert rst at clear cycle 8 -> sweep restarts; req_ready returns 16 cycles after rst release.
- Parity (SRAM_RESP_PARITY_EN): write addr 7 = 4'b0110 with err_inject=1, read addr 7 -> rd_data=4'b0110, par_err=1. Rewrite without inject and read -> par_err=0.

Source files
------------

// File: rtl/sram_resp_16x4.sv
// Responder for the 16x4 SRAM access protocol, with a clear sweep on reset and on request.
// Define SRAM_RESP_PARITY_EN to store a parity bit per entry and flag mismatches on reads.
module sram_resp_16x4 #(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_data,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          clr_req,
    output logic          busy,
`ifdef SRAM_RESP_PARITY_EN
    input  logic          err_inject,
`endif
    output logic          par_err
);

    localparam int unsigned DEPTH = 2 ** AW;
`ifdef SRAM_RESP_PARITY_EN
    localparam int unsigned EW = DW + 1;
`else
    localparam int unsigned EW = DW;
`endif

    typedef enum logic {
        StClear,
        StIdle
    } state_t;

    state_t        state;
    logic [AW-1:0] clr_ptr;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] wr_word;
    logic [EW-1:0] rd_word;
    logic          rd_hs;
    logic          wr_hs;

    assign req_ready = (state == StIdle) && !clr_req;
    assign busy      = (state == StClear);
    assign rd_hs     = req_valid && req_ready && !req_wr;
    assign wr_hs     = req_valid && req_ready && req_wr;
    assign rd_word   = mem[req_addr];

`ifdef SRAM_RESP_PARITY_EN
    assign wr_word = {(^req_data) ^ err_inject, req_data};
`else
    assign wr_word = req_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == StClear) begin
                mem[clr_ptr] <= '0;
            end else if (wr_hs) begin
                mem[req_addr] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StClear;
            clr_ptr  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_hs;
            if (rd_hs) begin
                rd_data <= rd_word[DW-1:0];
            end
            unique case (state)
                StClear: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == AW'(DEPTH - 1)) begin
                        state <= StIdle;
                    end
                end
                StIdle: begin
                    if (clr_req) begin
                        state   <= StClear;
                        clr_ptr <= '0;
                    end
                end
                default: state <= StClear;
            endcase
        end
    end

`ifdef SRAM_RESP_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= rd_hs && (rd_word[DW] != (^rd_word[DW-1:0]));
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_resp_16x4.sv
// Bench for sram_resp_16x4: behavioural array model checked every cycle plus directed literals.
module tb_sram_resp_16x4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_wr = 1'b0;
    logic [3:0] req_addr = 4'd0;
    logic [3:0] req_data = 4'd0;
    logic       clr_req = 1'b0;
    logic       err_inject = 1'b0;
    logic       req_ready;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic       busy;
    logic       par_err;

    sram_resp_16x4 #(.DW(4), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .clr_req   (clr_req),
        .busy      (busy),
`ifdef SRAM_RESP_PARITY_EN
        .err_inject(err_inject),
`endif
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: the clear is a count of busy cycles left; contents are zeroed when it begins.
    int         m_left = 16;
    logic       m_rv = 1'b0;
    logic [3:0] m_rd = 4'd0;
    logic       m_pe = 1'b0;
    logic [3:0] m_mem [16];
    logic       m_bad [16];
    logic       m_hs;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 16;
            m_rv   = 1'b0;
            m_rd   = 4'd0;
            m_pe   = 1'b0;
            for (int i = 0; i < 16; i++) begin
                m_mem[i] = 4'd0;
                m_bad[i] = 1'b0;
            end
        end else begin
            m_hs = req_valid && (m_left == 0) && !clr_req;
            m_rv = m_hs && !req_wr;
            m_pe = 1'b0;
            if (m_rv) begin
                m_rd = m_mem[req_addr];
                m_pe = m_bad[req_addr];
            end
            if (m_hs && req_wr) begin
                m_mem[req_addr] = req_data;
                m_bad[req_addr] = err_inject;
            end
            if (m_left > 0) begin
                m_left--;
            end else if (clr_req) begin
                m_left = 16;
                for (int i = 0; i < 16; i++) begin
                    m_mem[i] = 4'd0;
                    m_bad[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("req_ready", req_ready, (m_left == 0) && !clr_req);
            check("busy", busy, m_left != 0);
            check("rd_valid", rd_valid, m_rv);
            check("rd_data", rd_data, m_rd);
            check("par_err", par_err, m_pe);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        // Reset/clear timing with a read held pending.
        tick();
        check_en = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 4'd0;
        wait_ready(n);
        check("reset_ready_latency", n, 16);
        for (int i = 0; i < 16; i++) begin
            req_addr = 4'(i);
            tick();
            check("clear_read_valid", rd_valid, 1);
            check("clear_read_data", rd_data, 0);
        end
        req_valid = 1'b0;
        tick();

        // Golden sweep.
        req_valid = 1'b1;
        req_wr    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_addr = 4'(i);
            req_data = 4'(15 - i);
            tick();
        end
        req_wr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            req_addr = 4'(i);
            tick();
            check("sweep_valid", rd_valid, 1);
            check("sweep_data", rd_data, 15 - i);
        end
        req_valid = 1'b0;
        tick();
        check("sweep_valid_drop", rd_valid, 0);

        // Read-after-write.
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 4'd5;
        req_data  = 4'b1010;
        tick();
        req_wr = 1'b0;
        tick();
        check("raw_data", rd_data, 4'b1010);
        check("raw_valid", rd_valid, 1);

        // Read of addr 4, then clear collides with a write to addr 3.
        req_addr = 4'd4;
        tick();
        req_wr   = 1'b1;
        req_addr = 4'd3;
        req_data = 4'b0110;
        clr_req  = 1'b1;
        #1;
        check("prev_read_survives", rd_valid, 1);
        check("prev_read_data", rd_data, 11);
        check("collision_ready", req_ready, 0);
        tick();
        clr_req   = 1'b0;
        req_valid = 1'b0;
        wait_ready(n);
        check("clear_latency", n, 16);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 4'd3;
        tick();
        req_valid = 1'b0;
        check("collision_no_write", rd_data, 0);
        tick();

        // clr_req during the sweep is ignored.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (!req_ready && n < 40) begin
            clr_req = (n == 4);
            tick();
            n++;
        end
        clr_req = 1'b0;
        check("clear_ignores_clr_req", n, 16);

        // Reset at clear cycle 8 restarts the sweep.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(n);
        check("reset_mid_clear_latency", n, 16);

        // Reset right after a read accept drops the response.
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 4'd2;
        req_data  = 4'd9;
        tick();
        req_wr = 1'b0;
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        check("pre_reset_read", rd_data, 9);
        tick();
        check("reset_drops_valid", rd_valid, 0);
        rst = 1'b0;
        wait_ready(n);
        check("post_reset_latency", n, 16);

`ifdef SRAM_RESP_PARITY_EN
        req_valid  = 1'b1;
        req_wr     = 1'b1;
        req_addr   = 4'd7;
        req_data   = 4'b0110;
        err_inject = 1'b1;
        tick();
        err_inject = 1'b0;
        req_wr     = 1'b0;
        tick();
        check("parity_inject_data", rd_data, 4'b0110);
        check("parity_inject_err", par_err, 1);
        req_wr = 1'b1;
        tick();
        req_wr = 1'b0;
        tick();
        check("parity_clean_err", par_err, 0);
        req_valid = 1'b0;
        tick();
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
